array_unpacker: RTL

Stream-to-array deserializer and the receive-side counterpart of our array-port producers. It accepts one W-bit element per valid/ready beat and assembles M elements into a frame. It presents the frame simultaneously as an unpacked array port and as a packed mirror, with its own valid/ready output handshake. It sits between serial links and downstream logic, including TMR-triplicated logic, that consumes unpacked array ports.

---
 rtl/array_unpack_pkg.sv | 16 +
 rtl/array_unpacker_if.sv | 48 ++++
 rtl/array_unpack_parity_chk.sv | 54 +++++
 rtl/array_unpacker.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/array_unpack_pkg.sv
// Shared types and helpers for the array_unpacker stream-to-array deserializer.
// Optional parity checking is enabled by defining ARRAY_UNPACK_PARITY_EN.
package array_unpack_pkg;

  // Frame assembly state: FILL collects elements, HOLD presents the frame.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Width of an element counter that must represent 0..m inclusive.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/array_unpacker_if.sv
// Bus bundle for array_unpacker: serial element input plus the frame output.
// The slave modport is the deserializer's view, the master modport the
// producer/consumer side. in_parity/parity_err exist only when
// ARRAY_UNPACK_PARITY_EN is defined.
interface array_unpacker_if
  import array_unpack_pkg::*;
#(
  parameter int M = 2,
  parameter int W = 8
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          q [0:M-1];
  logic [M*W-1:0]        q_packed;
  logic [cnt_w(M)-1:0]   out_count;
  logic                  out_short;

`ifdef ARRAY_UNPACK_PARITY_EN
  logic                  in_parity;
  logic                  parity_err;

  modport slave (
    input  in_valid, in_data, in_last, in_parity, out_ready,
    output in_ready, out_valid, q, q_packed, out_count, out_short, parity_err
  );

  modport master (
    output in_valid, in_data, in_last, in_parity, out_ready,
    input  in_ready, out_valid, q, q_packed, out_count, out_short, parity_err
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, q, q_packed, out_count, out_short
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, q, q_packed, out_count, out_short
  );
`endif

endinterface

// File: rtl/array_unpack_parity_chk.sv
// Even-parity check of each accepted element plus a sticky per-frame flag.
// The flag is published when the frame closes and cleared when the frame is
// consumed. Only instantiated when ARRAY_UNPACK_PARITY_EN is defined.
module array_unpack_parity_chk #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] data,
  input  logic         parity,
  input  logic         accept,
  input  logic         close,
  input  logic         clear,
  output logic         err
);

  logic acc_q, acc_d;
  logic err_q, err_d;
  logic bad;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign bad = (^data) ^ parity;

  // Next-state for the running accumulator and the published frame flag.
  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end
    if (accept) begin
      if (close) begin
        err_d = acc_q | bad;
        acc_d = 1'b0;
      end else begin
        acc_d = acc_q | bad;
      end
    end
  end

  // Parity state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/array_unpacker.sv
// Stream-to-array deserializer: collects up to M W-bit elements per frame and
// presents them as an unpacked array plus a packed mirror with a valid/ready
// output handshake. Define ARRAY_UNPACK_PARITY_EN to add per-frame parity
// error reporting.
module array_unpacker
  import array_unpack_pkg::*;
#(
  parameter int M = 2,
  parameter int W = 8
) (
  input  logic            clock,
  input  logic            reset,
  array_unpacker_if.slave bus
);

  localparam int            CW  = cnt_w(M);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [W-1:0]   q_q [0:M-1];
  logic [W-1:0]   q_d [0:M-1];
  logic [CW-1:0]  count_q, count_d;
  logic           short_q, short_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic           accept;
  logic           close;
  logic           consume;
  logic [M*W-1:0] q_packed;

  // in_ready/out_valid come straight from flops, so neither depends
  // combinationally on the opposite handshake input.
  assign accept  = bus.in_valid & in_ready_q;
  assign close   = accept & (bus.in_last | (int'(idx_q) == M - 1));
  assign consume = out_valid_q & bus.out_ready;

  // Next-state logic for the FILL/HOLD frame assembler.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    q_d         = q_q;
    count_d     = count_q;
    short_d     = short_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < M; i++) begin
            if (i == int'(idx_q)) q_d[i] = bus.in_data;
          end
          idx_d = idx_q + ONE;
          if (close) begin
            // Short frame: blank the tail so stale elements never leak out.
            for (int i = 0; i < M; i++) begin
              if (i > int'(idx_q)) q_d[i] = '0;
            end
            count_d     = idx_q + ONE;
            short_d     = (int'(idx_q) + 1 < M);
            idx_d       = '0;
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          state_d     = FILL;
          idx_d       = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      count_q     <= '0;
      short_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      // NOTE: the element storage is reset on purpose: q is a visible output
      // that must read all-zero after reset, so it is flops, not a RAM.
      for (int i = 0; i < M; i++) q_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      short_q     <= short_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

  // Packed mirror: element i lands in bits [i*W +: W].
  always_comb begin
    q_packed = '0;
    for (int i = 0; i < M; i++) q_packed[i*W +: W] = q_q[i];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.q_packed  = q_packed;
  assign bus.out_count = count_q;
  assign bus.out_short = short_q;

`ifdef ARRAY_UNPACK_PARITY_EN
  logic parity_err;

  array_unpack_parity_chk #(
    .W (W)
  ) u_parity_chk (
    .clock  (clock),
    .reset  (reset),
    .data   (bus.in_data),
    .parity (bus.in_parity),
    .accept (accept),
    .close  (close),
    .clear  (consume),
    .err    (parity_err)
  );

  assign bus.parity_err = parity_err;
`endif

endmodule
